// File: rtl/sha256_round_engine.sv
`default_nettype none
// ============================================================================
// Module   : sha256_round_engine
// Brief    : Iterative SHA-256 compression, one round per clock (66-cycle block).
//            Optional macro SHA256_START_ABORT_EN: start outside IDLE restarts.
// Revision : 1.0 - initial release
// ============================================================================
module sha256_round_engine (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [511:0] block_in,
  input  logic [255:0] hash_in,
  output logic [5:0]   k_addr,
  input  logic [31:0]  k_in,
  output logic         busy,
  output logic         done,
  output logic [255:0] digest
);

`ifdef SHA256_START_ABORT_EN
  localparam logic c_ABORT_EN = 1'b1;
`else
  localparam logic c_ABORT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [5:0]     r_round;
  logic [31:0]    r_w  [16];
  logic [31:0]    r_hc [8];
  logic [31:0]    r_v  [8];
  logic           r_done;
  logic [255:0]   r_digest;

  logic           w_accept;
  logic           w_finish;
  logic [31:0]    w_t1;
  logic [31:0]    w_t2;
  logic [31:0]    w_wnew;

  function automatic logic [31:0] f_rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // FSM: next state and control outputs
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    busy        = 1'b0;
    k_addr      = 6'd0;
    case (r_state)
      S_IDLE: begin
        w_accept = start;
        if (start) w_state_nxt = S_ROUND;
      end
      S_ROUND: begin
        busy     = 1'b1;
        k_addr   = r_round;
        w_accept = start & c_ABORT_EN;
        if (!w_accept && r_round == 6'd63) w_state_nxt = S_FINAL;
      end
      S_FINAL: begin
        busy     = 1'b1;
        w_accept = start & c_ABORT_EN;
        w_finish = ~w_accept;
        w_state_nxt = w_accept ? S_ROUND : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Round datapath: r_v[0..7] hold a..h
  always_comb begin
    w_t1 = r_v[7]
         + (f_rotr(r_v[4], 6) ^ f_rotr(r_v[4], 11) ^ f_rotr(r_v[4], 25))
         + ((r_v[4] & r_v[5]) ^ (~r_v[4] & r_v[6]))
         + k_in + r_w[0];
    w_t2 = (f_rotr(r_v[0], 2) ^ f_rotr(r_v[0], 13) ^ f_rotr(r_v[0], 22))
         + ((r_v[0] & r_v[1]) ^ (r_v[0] & r_v[2]) ^ (r_v[1] & r_v[2]));
    w_wnew = (f_rotr(r_w[14], 17) ^ f_rotr(r_w[14], 19) ^ (r_w[14] >> 10))
           + r_w[9]
           + (f_rotr(r_w[1], 7) ^ f_rotr(r_w[1], 18) ^ (r_w[1] >> 3))
           + r_w[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_round  <= 6'd0;
      r_done   <= 1'b0;
      r_digest <= '0;
      for (int i = 0; i < 16; i++) r_w[i] <= '0;
      for (int i = 0; i < 8; i++) begin
        r_hc[i] <= '0;
        r_v[i]  <= '0;
      end
    end else begin
      r_done <= w_finish;
      if (w_accept) begin
        r_round <= 6'd0;
        for (int i = 0; i < 16; i++) r_w[i] <= block_in[511-32*i -: 32];
        for (int i = 0; i < 8; i++) begin
          r_hc[i] <= hash_in[255-32*i -: 32];
          r_v[i]  <= hash_in[255-32*i -: 32];
        end
      end else if (r_state == S_ROUND) begin
        r_round <= r_round + 6'd1;
        for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
        r_w[15] <= w_wnew;
        r_v[0]  <= w_t1 + w_t2;
        r_v[1]  <= r_v[0];
        r_v[2]  <= r_v[1];
        r_v[3]  <= r_v[2];
        r_v[4]  <= r_v[3] + w_t1;
        r_v[5]  <= r_v[4];
        r_v[6]  <= r_v[5];
        r_v[7]  <= r_v[6];
      end
      if (w_finish) begin
        for (int i = 0; i < 8; i++) r_digest[255-32*i -: 32] <= r_hc[i] + r_v[i];
      end
    end
  end

  assign done   = r_done;
  assign digest = r_digest;

endmodule
`default_nettype wire

// File: tb/tb_sha256_round_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256_round_engine
// Brief    : Scoreboard bench for sha256_round_engine with a full-schedule
//            SHA-256 reference model. Honours SHA256_START_ABORT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha256_round_engine;

`ifdef SHA256_START_ABORT_EN
  localparam bit c_ABORT = 1'b1;
`else
  localparam bit c_ABORT = 1'b0;
`endif

  localparam logic [255:0] c_IV    = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [511:0] c_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] c_EMPTY = {32'h80000000, 480'h0};
  localparam logic [255:0] c_D_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] c_D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

  logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [511:0] block_in = '0;
  logic [255:0] hash_in = '0;
  logic [5:0]   k_addr;
  logic [31:0]  k_in;
  logic         busy;
  logic         done;
  logic [255:0] digest;

  sha256_round_engine dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .block_in (block_in),
    .hash_in  (hash_in),
    .k_addr   (k_addr),
    .k_in     (k_in),
    .busy     (busy),
    .done     (done),
    .digest   (digest)
  );

  assign k_in = K_TAB[k_addr];

  always #5 clk = ~clk;

  int           cyc = 0;
  int           acc = -1;
  int           n_checks = 0;
  int           n_errors = 0;
  bit           mon_en = 1'b0;
  logic [255:0] exp_q [$];
  logic [255:0] model_digest = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook compression: full 64-word schedule expanded up front
  function automatic logic [255:0] sha_ref(input logic [511:0] b, input logic [255:0] hv);
    logic [31:0] W [64];
    logic [31:0] s [8];
    logic [31:0] t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) W[i] = b[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      W[i] = (rr(W[i-2], 17) ^ rr(W[i-2], 19) ^ (W[i-2] >> 10)) + W[i-7]
           + (rr(W[i-15], 7) ^ rr(W[i-15], 18) ^ (W[i-15] >> 3)) + W[i-16];
    for (int i = 0; i < 8; i++) s[i] = hv[255-32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = s[7] + (rr(s[4], 6) ^ rr(s[4], 11) ^ rr(s[4], 25))
         + ((s[4] & s[5]) ^ (~s[4] & s[6])) + K_TAB[t] + W[t];
      t2 = (rr(s[0], 2) ^ rr(s[0], 13) ^ rr(s[0], 22))
         + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
      for (int j = 7; j > 0; j--) s[j] = s[j-1];
      s[4] = s[4] + t1;
      s[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hv[255-32*i -: 32] + s[i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: timing expectations derived from the accept cycle of the block in flight
  always @(negedge clk) begin
    int d;
    logic exp_busy;
    logic exp_done;
    logic [5:0] exp_k;
    if (mon_en) begin
      d = (acc < 0) ? -1 : (cyc - acc);
      exp_busy = (d >= 1) && (d <= 65);
      exp_done = (d == 66);
      exp_k    = (d >= 1 && d <= 64) ? 6'(d - 1) : 6'd0;
      chk("busy", 256'(busy), 256'(exp_busy));
      chk("k_addr", 256'(k_addr), 256'(exp_k));
      chk("done", 256'(done), 256'(exp_done));
      if (done === 1'b1 || exp_done) begin
        if (exp_q.size() == 0) begin
          chk("done_without_expectation", 256'(done), 256'(0));
        end else begin
          model_digest = exp_q.pop_front();
        end
      end
      chk("digest", digest, model_digest);
    end
  end

  task automatic issue(input logic [511:0] b, input logic [255:0] hv, input logic [255:0] exp);
    int n;
    bit idle;
    n = cyc;
    idle = (acc < 0) || (n - acc >= 66);
    block_in = b;
    hash_in  = hv;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    block_in = {16{$urandom()}};
    hash_in  = {8{$urandom()}};
    if (idle || c_ABORT) begin
      if (!idle && exp_q.size() > 0) void'(exp_q.pop_back());
      exp_q.push_back(exp);
      acc = n;
    end
  endtask

  task automatic do_reset(input bit with_start);
    rst   = 1'b1;
    start = with_start;
    @(posedge clk); #1;
    rst   = 1'b0;
    start = 1'b0;
    acc   = -1;
    exp_q.delete();
    model_digest = '0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [511:0] rb;
    logic [255:0] rh;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    idle_cycles(2);

    // Known vectors, back-to-back with start in N+66
    issue(c_ABC, c_IV, c_D_ABC);
    idle_cycles(65);
    issue(c_EMPTY, c_IV, c_D_EMPTY);
    idle_cycles(70);

    // Reset at round 30, then a clean run
    issue(c_ABC, c_IV, c_D_ABC);
    idle_cycles(30);
    do_reset(1'b0);
    idle_cycles(3);
    issue(c_ABC, c_IV, c_D_ABC);
    idle_cycles(70);

    // Reset and start together: reset wins
    do_reset(1'b1);
    idle_cycles(3);

    // Second start at round 10
    issue(c_ABC, c_IV, c_D_ABC);
    idle_cycles(10);
    issue(c_EMPTY, c_IV, c_D_EMPTY);
    idle_cycles(75);

    // Randomised blocks and chaining values against the reference model
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 16; j++) rb[511-32*j -: 32] = $urandom();
      for (int j = 0; j < 8; j++) rh[255-32*j -: 32] = $urandom();
      issue(rb, rh, sha_ref(rb, rh));
      idle_cycles(65 + int'($urandom_range(0, 3)));
    end

    // Reference model sanity against the published vectors
    chk("ref_abc", sha_ref(c_ABC, c_IV), c_D_ABC);
    chk("ref_empty", sha_ref(c_EMPTY, c_IV), c_D_EMPTY);

    idle_cycles(75);
    chk("scoreboard_drained", 256'(exp_q.size()), 256'(0));
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
